comparator_serial_nbit: RTL and testbench
=========================================

Name: comparator_serial_nbit

Overview:
- Parametrised, multi-cycle magnitude comparator; successor of the 3-bit cascadable comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first, with optional early exit.
- Cascade inputs L/E/G decide the result when the operands are fully equal, so instances chain toward less-significant words.
- Sits in the datapath wherever wide operands are compared and single-cycle combinational depth is unacceptable; start/done handshake.

Parameters:
- WIDTH, 12, operand width in bits; must be a multiple of DIGIT (elaboration error otherwise).
- DIGIT, 3, bits compared per cycle; 1..WIDTH.
- SIGNED, 0, 1 = two's-complement compare (MSB of both operands inverted before compare); 0 = unsigned.
- EARLY_EXIT, 1, 1 = finish at the first unequal slice; 0 = always run all NDIG slices (fixed latency).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request; sampled only when not busy.
- a, input, WIDTH, operand A; captured on accepted start.
- b, input, WIDTH, operand B; captured on accepted start.
- L, input, 1, cascade less-than; captured on accepted start.
- E, input, 1, cascade equal; captured on accepted start.
- G, input, 1, cascade greater-than; captured on accepted start.
- busy, output, 1, high while slices are being compared.
- done, output, 1, one-cycle pulse; result valid this cycle.
- lt, output, 1, registered result.
- eq, output, 1, registered result.
- gt, output, 1, registered result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, lt=eq=gt=0, slice index=0. An aborted operation produces no done.
- Slice count: NDIG = WIDTH/DIGIT. Slice k = bits [k*DIGIT+DIGIT-1 : k*DIGIT]. Slices are processed from k=NDIG-1 down to 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 captures a, b, L, E, G; index <= NDIG-1; goes to RUN (busy=1 from next cycle).
- RUN: each cycle compares captured slice[index].
  - Unequal slice, no decision held yet: the decision (a>b or a<b) is latched.
  - EARLY_EXIT=1 and a decision is now latched: go to DONE.
  - index==0: go to DONE.
  - Otherwise: index decrements.
  - With EARLY_EXIT=0, later unequal slices never overwrite the first decision.
- Result written at the transition into DONE:
  - gt = (a>b) | (all_equal & G)
  - lt = (a<b) | (all_equal & L)
  - eq = all_equal & E
  - Cascade flags pass through unfiltered; E=G=1 with a==b gives eq=gt=1.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle bubble).
- lt/eq/gt hold their value until the next result is written. An accepted start does not clear them.
- start while in RUN is ignored; captured operands are not disturbed by input changes during RUN.
- Latency: start accepted at edge t gives done high in cycle t+1+n, where n = slices evaluated (1..NDIG). n=NDIG when EARLY_EXIT=0 or operands are equal.
- SIGNED=1: bit WIDTH-1 of both captured operands is inverted before comparison (offset-binary); slices are otherwise unsigned.

Decomposition:
- Shared package comparator_pkg holds:
  - state encoding localparams ST_IDLE/ST_RUN/ST_DONE (2 bits);
  - a clog2-based index-width function used for NDIG.
- Sub-module comparator_digit (parameter DIGIT): purely combinational; inputs a_s, b_s; outputs s_gt, s_lt, s_eq. Instantiated once, fed the currently selected slice.

Test Plan:
- WIDTH=12, DIGIT=3, a=12'hABC, b=12'hABC, E=1, L=G=0 -> eq=1, lt=gt=0; done in cycle t+5; busy high t+1..t+4.
- a=12'h800, b=12'h7FF, EARLY_EXIT=1 -> gt=1, done in cycle t+2. Same case with EARLY_EXIT=0 -> gt=1, done in cycle t+5.
- SIGNED=1, a=12'h800 (-2048), b=12'h001 -> lt=1, gt=0, eq=0.
- a=b=12'h123, E=0, G=1, L=0 -> gt=1, eq=0, lt=0 (cascade pass-through).
- start pulsed with a different a,b during RUN -> ignored; result matches first operands; start in the DONE cycle -> second result done exactly n2+1 cycles later.
- rst asserted mid-RUN -> busy, done, lt, eq, gt all 0 immediately (asynchronous); no done pulse; next start operates normally.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state
// encoding and the index-width helper used to size the slice counter.
package comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/comparator_digit.sv
// Combinational magnitude compare of one DIGIT-bit slice pair.
module comparator_digit #(
    parameter int DIGIT = 3
) (
    input  logic [DIGIT-1:0] a_s,
    input  logic [DIGIT-1:0] b_s,
    output logic             s_gt,
    output logic             s_lt,
    output logic             s_eq
);

    assign s_gt = (a_s > b_s);
    assign s_lt = (a_s < b_s);
    assign s_eq = (a_s == b_s);

endmodule

// File: rtl/comparator_serial_nbit.sv
// Multi-cycle WIDTH-bit magnitude comparator, one DIGIT-bit slice per clock,
// MSB slice first, with cascade inputs deciding fully-equal operands.
module comparator_serial_nbit
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int DIGIT      = 3,
    parameter int SIGNED     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             L,
    input  logic             E,
    input  logic             G,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [1:0]       dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = idx_width(NDIG);
    localparam logic [IW-1:0]    IDX_TOP = IW'(NDIG - 1);
    localparam logic [WIDTH-1:0] SMASK   = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("comparator_serial_nbit: WIDTH must be a non-zero multiple of DIGIT");
    end

    // Handshake: start is accepted on any rising edge where the FSM is in
    // IDLE or DONE (not busy); operands and cascade flags are captured then.
    // done pulses for exactly one cycle with lt/eq/gt already valid; the
    // result registers hold until the next result is written.
    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             l_q, e_q, g_q;
    logic             dec_q, dec_d;
    logic             dgt_q, dgt_d;
    logic             lt_q, eq_q, gt_q;
    logic             lt_d, eq_d, gt_d;
    logic             load;
    logic             wr_res;

    logic [DIGIT-1:0] a_s, b_s;
    logic             s_gt, s_lt, s_eq;

    assign a_s = a_q[idx_q*DIGIT +: DIGIT];
    assign b_s = b_q[idx_q*DIGIT +: DIGIT];

    comparator_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_s  (a_s),
        .b_s  (b_s),
        .s_gt (s_gt),
        .s_lt (s_lt),
        .s_eq (s_eq)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        dgt_d   = dgt_q;
        load    = 1'b0;
        wr_res  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                    idx_d   = IDX_TOP;
                    dec_d   = 1'b0;
                    dgt_d   = 1'b0;
                end
            end
            ST_RUN: begin
                // Only the first unequal slice (from the MSB side) decides.
                if (!dec_q && !s_eq) begin
                    dec_d = 1'b1;
                    dgt_d = s_gt;
                end
                if (((EARLY_EXIT != 0) && dec_d) || (idx_q == '0)) begin
                    state_d = ST_DONE;
                    wr_res  = 1'b1;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // With no decision held the operands are fully equal and the cascade
    // flags pass straight through, unfiltered.
    assign gt_d = dec_d ? dgt_d  : g_q;
    assign lt_d = dec_d ? !dgt_d : l_q;
    assign eq_d = !dec_d & e_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            dec_q   <= 1'b0;
            dgt_q   <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            dgt_q   <= dgt_d;
            if (load) begin
                a_q <= a ^ SMASK;
                b_q <= b ^ SMASK;
                l_q <= L;
                e_q <= E;
                g_q <= G;
            end
            if (wr_res) begin
                lt_q <= lt_d;
                eq_q <= eq_d;
                gt_q <= gt_d;
            end
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Bench for comparator_serial_nbit: three instances (unsigned early-exit,
// unsigned fixed-latency, signed early-exit) driven with shared stimulus.
module tb_comparator_serial_nbit;

    localparam int NDIG = 4;
    localparam int ND   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] a_i, b_i;
    logic        l_i, e_i, g_i;
    logic [ND-1:0] busy_w, done_w, lt_w, eq_w, gt_w;
    logic [1:0]  st_w [ND];

    int n_asserts = 0;
    int n_fail    = 0;

    bit exp_lt [ND];
    bit exp_eq [ND];
    bit exp_gt [ND];
    int exp_n  [ND];
    bit cur_lt [ND];
    bit cur_eq [ND];
    bit cur_gt [ND];

    always #5 clk = ~clk;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        comparator_serial_nbit #(
            .WIDTH      (12),
            .DIGIT      (3),
            .SIGNED     ((i == 2) ? 1 : 0),
            .EARLY_EXIT ((i == 1) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .a         (a_i),
            .b         (b_i),
            .L         (l_i),
            .E         (e_i),
            .G         (g_i),
            .busy      (busy_w[i]),
            .done      (done_w[i]),
            .lt        (lt_w[i]),
            .eq        (eq_w[i]),
            .gt        (gt_w[i]),
            .dbg_state (st_w[i])
        );
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int d, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %b expected %b at %0t", tag, d, obs, exp, $time);
        end
    endtask

    // Reference: magnitude from integer arithmetic; latency from the position
    // of the most significant differing 3-bit digit.
    function automatic void model(input logic [11:0] a, input logic [11:0] b,
                                  input bit l, input bit e, input bit g,
                                  input bit sgn, input bit ee,
                                  output bit lt, output bit eq, output bit gt,
                                  output int n);
        int  sa, sb;
        bit  found;
        sa = sgn ? int'($signed(a)) : int'(a);
        sb = sgn ? int'($signed(b)) : int'(b);
        lt = (sa < sb) || ((a == b) && l);
        gt = (sa > sb) || ((a == b) && g);
        eq = (a == b) && e;
        n = NDIG;
        found = 1'b0;
        if (ee && (a != b)) begin
            for (int k = NDIG - 1; k >= 0; k--) begin
                if (!found && (((a >> (3 * k)) & 12'h7) != ((b >> (3 * k)) & 12'h7))) begin
                    n = NDIG - k;
                    found = 1'b1;
                end
            end
        end
    endfunction

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk({tag, "_busy"}, d, busy_w[d], 1'b0);
            chk({tag, "_done"}, d, done_w[d], 1'b0);
            chk({tag, "_lt"}, d, lt_w[d], cur_lt[d]);
            chk({tag, "_eq"}, d, eq_w[d], cur_eq[d]);
            chk({tag, "_gt"}, d, gt_w[d], cur_gt[d]);
        end
    endtask

    // Presents an operation and waits for the accepting edge.
    task automatic start_op(input logic [11:0] a, input logic [11:0] b,
                            input bit l, input bit e, input bit g);
        a_i = a; b_i = b; l_i = l; e_i = e; g_i = g;
        start = 1'b1;
        for (int d = 0; d < ND; d++)
            model(a, b, l, e, g, d == 2, d != 1, exp_lt[d], exp_eq[d], exp_gt[d], exp_n[d]);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk("accept_busy", d, busy_w[d], 1'b1);
            chk("accept_done", d, done_w[d], 1'b0);
        end
    endtask

    // Follows the operation edge by edge; chain leaves all instances in DONE.
    task automatic track(input bit chain, input bit poke);
        int maxn;
        maxn = 0;
        for (int d = 0; d < ND; d++) if (exp_n[d] > maxn) maxn = exp_n[d];
        for (int c = 1; c <= maxn; c++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < ND; d++) begin
                if (c == exp_n[d]) begin
                    cur_lt[d] = exp_lt[d];
                    cur_eq[d] = exp_eq[d];
                    cur_gt[d] = exp_gt[d];
                end
                chk("run_busy", d, busy_w[d], c < exp_n[d]);
                chk("run_done", d, done_w[d], c == exp_n[d]);
                chk("run_lt", d, lt_w[d], cur_lt[d]);
                chk("run_eq", d, eq_w[d], cur_eq[d]);
                chk("run_gt", d, gt_w[d], cur_gt[d]);
            end
            if (poke && c == 1) begin
                start = 1'b1;
                a_i = 12'($urandom);
                b_i = ~a_i;
                l_i = 1'b1; e_i = 1'b0; g_i = 1'b1;
            end
            if (poke && c == 2) start = 1'b0;
        end
        if (!chain) begin
            @(posedge clk);
            #1;
            check_idle_all("after");
        end
    endtask

    initial begin
        logic [11:0] ra, rb;
        int mode;
        rst = 1'b1; start = 1'b0;
        a_i = '0; b_i = '0; l_i = 1'b0; e_i = 1'b0; g_i = 1'b0;
        for (int d = 0; d < ND; d++) begin
            cur_lt[d] = 1'b0; cur_eq[d] = 1'b0; cur_gt[d] = 1'b0;
        end
        #22;
        check_idle_all("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_op(12'hABC, 12'hABC, 1'b0, 1'b1, 1'b0);
        track(1'b0, 1'b0);
        start_op(12'h800, 12'h7FF, 1'b0, 1'b0, 1'b0);
        track(1'b0, 1'b0);
        start_op(12'h800, 12'h001, 1'b0, 1'b0, 1'b0);
        track(1'b0, 1'b0);
        start_op(12'h123, 12'h123, 1'b0, 1'b0, 1'b1);
        track(1'b0, 1'b0);
        start_op(12'h5A5, 12'h5A5, 1'b0, 1'b1, 1'b1);
        track(1'b0, 1'b0);

        // start during RUN ignored, then back-to-back start in the DONE cycle
        start_op(12'h555, 12'h555, 1'b1, 1'b1, 1'b0);
        track(1'b1, 1'b1);
        start_op(12'h0F0, 12'h0E0, 1'b0, 1'b0, 1'b0);
        track(1'b0, 1'b0);

        // asynchronous reset in the middle of RUN
        start_op(12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            cur_lt[d] = 1'b0; cur_eq[d] = 1'b0; cur_gt[d] = 1'b0;
        end
        check_idle_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check_idle_all("post_rst");
        end
        start_op(12'h7FF, 12'h800, 1'b0, 1'b0, 1'b0);
        track(1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            ra = 12'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0: rb = 12'($urandom);
                1: rb = ra;
                2: rb = ra ^ (12'($urandom_range(1, 7)) << (3 * $urandom_range(0, 3)));
                default: rb = ra ^ 12'h800;
            endcase
            start_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
            track(1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
